// File: rtl/usb_phy_pkg.sv
// Shared definitions for the USB PHY transmit path: sequencer states,
// the default SYNC byte and the LSB-first/MSB-first bit-order helper.
package usb_phy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC_LD,
      ST_SYNC_WT,
      ST_DATA_LD,
      ST_DATA_WT,
      ST_EOP
   } tx_state_e;

   localparam logic [7:0] SYNC_PATTERN_DEFAULT = 8'h80;

   function automatic logic [7:0] bitrev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

endpackage

// File: rtl/usb_tx_sequencer.sv
// UTMI transmit sequencer: frames a packet as SYNC bytes, data bytes and EOP,
// handing each byte to an external serializer and waiting for its done pulse.
module usb_tx_sequencer
   import usb_phy_pkg::*;
#(
   parameter int         SYNC_BYTES   = 1,
   parameter logic [7:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
   parameter int         EOP_TIMEOUT  = 64
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_tx_valid,
   input  logic [7:0] i_tx_data,
   output logic       o_tx_ready,
   output logic [7:0] o_ser_data,
   output logic       o_ser_valid,
   output logic       o_ser_load,
   input  logic       i_ser_done,
   output logic       o_eop_req,
   input  logic       i_eop_done,
   output logic       o_tx_active,
   output logic       o_eop_timeout
);

   localparam int SYNC_CNT_W = $clog2(SYNC_BYTES + 1);
   localparam int TMO_CNT_W  = $clog2(EOP_TIMEOUT);

   localparam logic [SYNC_CNT_W-1:0] SYNC_LAST = SYNC_CNT_W'(SYNC_BYTES);
   localparam logic [TMO_CNT_W-1:0]  TMO_LAST  = TMO_CNT_W'(EOP_TIMEOUT - 1);
   localparam logic [7:0]            SYNC_WIRE = bitrev8(SYNC_PATTERN);

   tx_state_e             r_state;
   logic [SYNC_CNT_W-1:0] r_sync_cnt;
   logic [TMO_CNT_W-1:0]  r_tmo_cnt;
   logic [7:0]            r_ser_data;
   logic                  r_ser_load;
   logic                  r_ser_valid;
   logic                  r_tx_ready;
   logic                  r_eop_req;
   logic                  r_tx_active;
   logic                  r_eop_timeout;
   logic [7:0]            w_data_wire;

   assign w_data_wire = bitrev8(i_tx_data);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_sync_cnt    <= '0;
         r_tmo_cnt     <= '0;
         r_ser_data    <= '0;
         r_ser_load    <= 1'b0;
         r_ser_valid   <= 1'b0;
         r_tx_ready    <= 1'b0;
         r_eop_req     <= 1'b0;
         r_tx_active   <= 1'b0;
         r_eop_timeout <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle so each one is exactly one cycle wide.
         r_ser_data    <= '0;
         r_ser_load    <= 1'b0;
         r_ser_valid   <= 1'b0;
         r_tx_ready    <= 1'b0;
         r_eop_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_sync_cnt <= '0;
               r_tmo_cnt  <= '0;
               if (i_tx_valid) begin
                  r_state     <= ST_SYNC_LD;
                  r_tx_active <= 1'b1;
                  r_ser_load  <= 1'b1;
                  r_ser_valid <= 1'b1;
                  r_ser_data  <= SYNC_WIRE;
               end
            end
            ST_SYNC_LD: begin
               r_state    <= ST_SYNC_WT;
               r_sync_cnt <= r_sync_cnt + SYNC_CNT_W'(1);
            end
            ST_SYNC_WT: begin
               if (i_ser_done) begin
                  if (r_sync_cnt < SYNC_LAST) begin
                     r_state     <= ST_SYNC_LD;
                     r_ser_load  <= 1'b1;
                     r_ser_valid <= 1'b1;
                     r_ser_data  <= SYNC_WIRE;
                  end else if (i_tx_valid) begin
                     r_state     <= ST_DATA_LD;
                     r_ser_load  <= 1'b1;
                     r_ser_valid <= 1'b1;
                     r_tx_ready  <= 1'b1;
                  end else begin
                     r_state   <= ST_EOP;
                     r_eop_req <= 1'b1;
                     r_tmo_cnt <= '0;
                  end
               end
            end
            ST_DATA_LD: begin
               r_state <= ST_DATA_WT;
            end
            ST_DATA_WT: begin
               if (i_ser_done) begin
                  if (i_tx_valid) begin
                     r_state     <= ST_DATA_LD;
                     r_ser_load  <= 1'b1;
                     r_ser_valid <= 1'b1;
                     r_tx_ready  <= 1'b1;
                  end else begin
                     r_state   <= ST_EOP;
                     r_eop_req <= 1'b1;
                     r_tmo_cnt <= '0;
                  end
               end
            end
            ST_EOP: begin
               // A done arriving on the last timeout cycle still counts as success.
               if (i_eop_done) begin
                  r_state     <= ST_IDLE;
                  r_eop_req   <= 1'b0;
                  r_tx_active <= 1'b0;
                  r_tmo_cnt   <= '0;
               end else if (r_tmo_cnt == TMO_LAST) begin
                  r_state       <= ST_IDLE;
                  r_eop_req     <= 1'b0;
                  r_tx_active   <= 1'b0;
                  r_eop_timeout <= 1'b1;
                  r_tmo_cnt     <= '0;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TMO_CNT_W'(1);
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_eop_req   <= 1'b0;
               r_tx_active <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: the data byte bypasses the register so the UTMI byte is taken in the DATA_LD cycle itself.
   assign o_ser_data    = (r_state == ST_DATA_LD) ? w_data_wire : r_ser_data;
   assign o_ser_load    = r_ser_load;
   assign o_ser_valid   = r_ser_valid;
   assign o_tx_ready    = r_tx_ready;
   assign o_eop_req     = r_eop_req;
   assign o_tx_active   = r_tx_active;
   assign o_eop_timeout = r_eop_timeout;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Bench for usb_tx_sequencer: FS (1 SYNC byte) and HS (4 SYNC bytes) lanes run
// random packets against a cycle-timeline model of the packet framing rules.
module tb_usb_tx_sequencer;

   typedef struct packed {
      logic       load;
      logic       ready;
      logic [7:0] data;
      logic       eop_req;
      logic       active;
      logic       tmo;
   } exp_t;

   logic clk;
   int   cyc;
   int   n_checks;
   int   n_pass;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      n_checks = 0;
      n_pass   = 0;
   end

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int SB = (g == 0) ? 1 : 4;

      logic       rst_n, tx_valid, ser_done, eop_done;
      logic [7:0] tx_data;
      logic       tx_ready, ser_valid, ser_load, eop_req, tx_active, eop_tmo;
      logic [7:0] ser_data;

      int         t0, n, k, done_at, idx, eop_rise;
      bit         has_pkt, model_on, prev_ready, prev_req, fin;
      logic [7:0] pkt [8];

      usb_tx_sequencer #(
         .SYNC_BYTES  (SB),
         .SYNC_PATTERN(8'h80),
         .EOP_TIMEOUT (64)
      ) u_dut (
         .i_clk        (clk),
         .i_rst_n      (rst_n),
         .i_tx_valid   (tx_valid),
         .i_tx_data    (tx_data),
         .o_tx_ready   (tx_ready),
         .o_ser_data   (ser_data),
         .o_ser_valid  (ser_valid),
         .o_ser_load   (ser_load),
         .i_ser_done   (ser_done),
         .o_eop_req    (eop_req),
         .i_eop_done   (eop_done),
         .o_tx_active  (tx_active),
         .o_eop_timeout(eop_tmo)
      );

      // Expected outputs in cycle c: loads every 10 cycles from t0+1, EOP after the last byte.
      function automatic exp_t model(input int c);
         exp_t x;
         int   e, fin_c, rel;
         bit   tmo_case;
         x = '0;
         if (!has_pkt || c <= t0) return x;
         e = t0 + 1 + 10 * (SB + n);
         if (c < e) begin
            rel      = c - t0 - 1;
            x.active = 1'b1;
            if (rel % 10 == 0) begin
               x.load = 1'b1;
               if (rel / 10 < SB) x.data = 8'h01;
               else begin
                  x.ready = 1'b1;
                  x.data  = rev8(pkt[rel / 10 - SB]);
               end
            end
            return x;
         end
         tmo_case = (k < 0);
         fin_c    = tmo_case ? e + 64 : e + k + 1;
         if (c < fin_c) begin
            x.eop_req = 1'b1;
            x.active  = 1'b1;
         end else if (tmo_case && c == e + 64) begin
            x.tmo = 1'b1;
         end
         return x;
      endfunction

      // Serializer: done 9 cycles after each load, plus stray dones where they must be ignored.
      initial begin
         ser_done = 1'b0;
         forever begin
            @(posedge clk);
            #1;
            ser_done = (cyc == done_at) ||
                       ((eop_req || ser_load || !tx_active) && $urandom_range(0, 7) == 0);
         end
      end

      initial begin
         exp_t x;
         done_at = -100;
         forever begin
            @(negedge clk);
            if (ser_load) done_at = cyc + 9;
            if (model_on) begin
               x = model(cyc);
               check($sformatf("lane%0d load c%0d", g, cyc), 32'(ser_load), 32'(x.load));
               check($sformatf("lane%0d valid c%0d", g, cyc), 32'(ser_valid), 32'(x.load));
               check($sformatf("lane%0d ready c%0d", g, cyc), 32'(tx_ready), 32'(x.ready));
               check($sformatf("lane%0d eop_req c%0d", g, cyc), 32'(eop_req), 32'(x.eop_req));
               check($sformatf("lane%0d active c%0d", g, cyc), 32'(tx_active), 32'(x.active));
               check($sformatf("lane%0d timeout c%0d", g, cyc), 32'(eop_tmo), 32'(x.tmo));
               if (x.load)
                  check($sformatf("lane%0d data c%0d", g, cyc), 32'(ser_data), 32'(x.data));
            end
         end
      end

      task automatic check_all_zero(input string tag);
         check({tag, "_data"},    32'(ser_data),  32'h0);
         check({tag, "_load"},    32'(ser_load),  32'h0);
         check({tag, "_valid"},   32'(ser_valid), 32'h0);
         check({tag, "_ready"},   32'(tx_ready),  32'h0);
         check({tag, "_eop_req"}, 32'(eop_req),   32'h0);
         check({tag, "_active"},  32'(tx_active), 32'h0);
         check({tag, "_timeout"}, 32'(eop_tmo),   32'h0);
      endtask

      task automatic do_reset();
         model_on = 1'b0;
         #2 rst_n = 1'b0;
         #1 check_all_zero($sformatf("lane%0d rst_async", g));
         has_pkt  = 1'b0;
         tx_valid = 1'b0;
         eop_done = 1'b0;
         repeat (3) @(posedge clk);
         #2 rst_n = 1'b1;
         model_on = 1'b1;
         repeat (4) @(posedge clk);
      endtask

      // One packet of nb bytes; kk is the EOP-done offset from EOP entry, -1 for none.
      task automatic run_pkt(input int nb, input int kk, input bit abort);
         int e;
         @(posedge clk);
         #1;
         t0 = cyc;
         n  = nb;
         k  = kk;
         has_pkt    = 1'b1;
         idx        = 0;
         prev_ready = 1'b0;
         prev_req   = 1'b0;
         eop_rise   = 0;
         tx_valid   = 1'b1;
         tx_data    = (nb > 0) ? pkt[0] : 8'($urandom);
         e = t0 + 1 + 10 * (SB + nb);
         while (cyc < e + 66) begin
            @(posedge clk);
            #1;
            if (abort && cyc == t0 + 1 + 10 * SB + 4) begin
               do_reset();
               return;
            end
            if (prev_ready) idx++;
            prev_ready = tx_ready;
            if (eop_req && !prev_req) eop_rise = cyc;
            prev_req = eop_req;
            eop_done = (kk >= 0) && eop_req && (cyc - eop_rise == kk);
            if (eop_req)          tx_valid = 1'($urandom_range(0, 1));
            else if (nb == 0)     tx_valid = (cyc - t0 < 2);
            else if (idx < nb)    tx_valid = !(tx_active && cyc != done_at && $urandom_range(0, 3) == 0);
            else                  tx_valid = 1'b0;
            tx_data = (idx < nb) ? pkt[idx] : 8'($urandom);
         end
         eop_done = 1'b0;
         tx_valid = 1'b0;
      endtask

      initial begin
         int nb, kr;
         fin      = 1'b0;
         rst_n    = 1'b0;
         tx_valid = 1'b0;
         tx_data  = 8'h00;
         eop_done = 1'b0;
         model_on = 1'b0;
         has_pkt  = 1'b0;
         t0 = 0; n = 0; k = -1;
         repeat (3) @(posedge clk);
         #1 check_all_zero($sformatf("lane%0d reset", g));
         #1 rst_n = 1'b1;
         model_on = 1'b1;
         repeat (2) @(posedge clk);
         if (g == 0) begin
            pkt[0] = 8'h12;
            pkt[1] = 8'h34;
            run_pkt(2, 5, 1'b0);
            run_pkt(0, -1, 1'b0);
            pkt[0] = 8'($urandom);
            run_pkt(1, 63, 1'b0);
         end else begin
            pkt[0] = 8'hA5;
            run_pkt(1, 0, 1'b0);
         end
         pkt[0] = 8'h5A;
         pkt[1] = 8'hC3;
         run_pkt(2, 10, 1'b1);
         pkt[0] = 8'h77;
         run_pkt(1, 2, 1'b0);
         for (int p = 0; p < 16; p++) begin
            nb = $urandom_range(0, 4);
            kr = $urandom_range(0, 79);
            for (int i = 0; i < 8; i++) pkt[i] = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_pkt(nb, (kr < 64) ? kr : -1, 1'b0);
         end
         fin = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 60000 && !(lane[0].fin && lane[1].fin); i++) @(posedge clk);
      check("lanes_finished", 32'({lane[1].fin, lane[0].fin}), 32'h3);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/usb_tx_sequencer.md
USB_TX_SEQUENCER -- requirements
Module: usb_tx_sequencer

Interface
REQ-001 SHALL have parameter SYNC_BYTES, default 1, meaning the number of SYNC bytes sent before packet data (4 for HS).
REQ-002 SHALL have parameter SYNC_PATTERN, default 8'h80, meaning the SYNC byte in LSB-first wire order.
REQ-003 SHALL have parameter EOP_TIMEOUT, default 64, meaning the maximum number of cycles to wait for i_eop_done.
REQ-004 SHALL have port i_clk, input, 1, the single clock.
REQ-005 SHALL have port i_rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port i_tx_valid, input, 1, UTMI TxValid (packet in progress).
REQ-007 SHALL have port i_tx_data, input, 8, UTMI DataIn, LSB-first byte.
REQ-008 SHALL have port o_tx_ready, output, 1, UTMI TxReady; a one-cycle pulse that accepts i_tx_data.
REQ-009 SHALL have port o_ser_data, output, 8, the byte to the serializer, MSB-first order.
REQ-010 SHALL have port o_ser_valid, output, 1, serializer data valid.
REQ-011 SHALL have port o_ser_load, output, 1, serializer load strobe.
REQ-012 SHALL have port i_ser_done, input, 1, serializer one-cycle completion pulse.
REQ-013 SHALL have port o_eop_req, output, 1, level request to the line driver to emit EOP.
REQ-014 SHALL have port i_eop_done, input, 1, EOP complete.
REQ-015 SHALL have port o_tx_active, output, 1, high from SYNC start through EOP end.
REQ-016 SHALL have port o_eop_timeout, output, 1, a one-cycle error pulse.

Function
REQ-017 SHALL implement the states IDLE, SYNC_LD, SYNC_WT, DATA_LD, DATA_WT, EOP.
REQ-018 In IDLE, when i_tx_valid=1, SHALL go to SYNC_LD on the next edge and clear the sync counter.
REQ-019 SYNC_LD SHALL last exactly one cycle, with o_ser_load=o_ser_valid=1 and o_ser_data=bitrev(SYNC_PATTERN); it then goes to SYNC_WT.
REQ-020 SYNC_WT SHALL hold outputs low until i_ser_done=1, then:
- if fewer than SYNC_BYTES SYNC bytes have been sent, go to SYNC_LD;
- otherwise, go to DATA_LD if i_tx_valid=1, else go to EOP.
REQ-021 DATA_LD SHALL last exactly one cycle, with o_ser_load=o_ser_valid=o_tx_ready=1 and o_ser_data=bitrev(i_tx_data) sampled in that same cycle; it then goes to DATA_WT.
REQ-022 DATA_WT SHALL wait for i_ser_done=1, then go to DATA_LD if i_tx_valid=1, else go to EOP.
REQ-023 The load-to-load period SHALL be 10 cycles: load, 8 shift cycles, done cycle.
REQ-024 i_tx_valid deasserting during SYNC_LD/SYNC_WT/DATA_WT SHALL NOT abort the byte in flight; it is evaluated only on i_ser_done.
REQ-025 A packet with zero data bytes (i_tx_valid low at the last SYNC done) SHALL go directly to EOP; o_tx_ready never pulses.
REQ-026 In EOP, o_eop_req SHALL be 1 and the timeout counter SHALL increment each cycle.
REQ-027 In EOP, i_eop_done=1 SHALL return the block to IDLE on the next edge.
REQ-028 If the timeout counter reaches EOP_TIMEOUT-1 with i_eop_done=0, the block SHALL pulse o_eop_timeout for one cycle and return to IDLE.
REQ-029 If i_eop_done and the timeout occur in the same cycle, i_eop_done SHALL win and there is no error pulse.
REQ-030 i_tx_valid during EOP SHALL be ignored; a new packet starts only from IDLE, so at least one IDLE cycle separates packets.
REQ-031 An i_ser_done pulse in IDLE, SYNC_LD, DATA_LD or EOP SHALL be ignored.
REQ-032 o_tx_active SHALL be 1 in every state except IDLE.
REQ-033 o_ser_load, o_ser_valid and o_tx_ready SHALL be registered outputs that are never high outside the *_LD states.
REQ-034 Counter widths SHALL be $clog2(SYNC_BYTES+1) for the sync counter and $clog2(EOP_TIMEOUT) for the timeout counter, with no wrap-around reachable.

Reset
REQ-035 Asserting i_rst_n low SHALL immediately force IDLE, clear both counters, and drive o_ser_data=8'h00 and all 1-bit outputs to 0.
REQ-036 Reset asserted mid-byte or mid-EOP SHALL abandon the packet; after release, the block waits in IDLE for a fresh i_tx_valid.

Structure
REQ-037 The state enum, the SYNC_PATTERN default and a bitrev8 function SHALL reside in the shared package usb_phy_pkg.
REQ-038 No sub-module SHALL be instantiated; parallel_to_serial SHALL be instantiated beside this block in the PHY TX top level.

Verification
REQ-039 SYNC_BYTES=1, i_tx_valid held high with data 0x12 then 0x34, then dropped -> o_ser_data sequence 0x01, 0x48, 0x2C; loads 10 cycles apart; two o_tx_ready pulses; o_eop_req follows.
REQ-040 SYNC_BYTES=4, one data byte -> four loads of 0x01 before the data load.
REQ-041 i_tx_valid pulses for 2 cycles only -> SYNC sent, zero o_tx_ready pulses, direct entry to EOP.
REQ-042 In EOP with i_eop_done held low -> o_eop_timeout pulses exactly 64 cycles after EOP entry, then IDLE.
REQ-043 Reset asserted 4 cycles into a data byte -> all outputs are 0 asynchronously; a new packet after release starts again with SYNC.
REQ-044 i_eop_done coincident with the final timeout cycle -> no o_eop_timeout pulse; IDLE on the next edge.
